// File: rtl/clk_10k_gen.sv
// clk_10k_gen: glitch-free programmable divider producing clk_10k from clk_sys; define CLK_10K_GEN_STROBE_EN to build the clk_10k_en strobe
module clk_10k_gen #(
  parameter int CNT_W       = 16,
  parameter int DIV_DEFAULT = 4000
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic             run,
  input  logic             div_wr,
  input  logic [CNT_W-1:0] div_in,
  output logic             div_ack,
  output logic             div_err,
  output logic             clk_10k,
  output logic             clk_10k_en
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, div_act, act_n, div_pend, pend_n, half;
  logic pend_v, pend_v_n, clk_n, bnd, apply, bad, good_wr;
  assign half     = div_act >> 1;
  assign bnd      = (state == IDLE) || (cnt == div_act - CNT_W'(1));
  assign apply    = bnd && pend_v;
  assign bad      = div_in < CNT_W'(2);
  assign good_wr  = div_wr && !bad;
  assign act_n    = apply ? div_pend : div_act;
  assign pend_n   = good_wr ? div_in : div_pend;
  assign pend_v_n = good_wr || (pend_v && !apply);
  // period boundaries (idle or wrap) restart the count and open a high phase only while run is held
  always_comb begin
    state_n = bnd ? (run ? RUN : IDLE) : state;
    cnt_n   = bnd ? '0 : cnt + CNT_W'(1);
    clk_n   = bnd ? run : (cnt == half - CNT_W'(1) ? 1'b0 : clk_10k);
  end
  // state, counter, divisor bookkeeping and registered outputs
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      clk_10k  <= 1'b0;
      div_ack  <= 1'b0;
      div_err  <= 1'b0;
      div_act  <= CNT_W'(DIV_DEFAULT);
      div_pend <= '0;
      pend_v   <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      clk_10k  <= clk_n;
      div_ack  <= apply;
      div_err  <= div_wr && bad;
      div_act  <= act_n;
      div_pend <= pend_n;
      pend_v   <= pend_v_n;
    end
  end
`ifdef CLK_10K_GEN_STROBE_EN
  // strobe flags the edge on which clk_10k goes from low to high
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) clk_10k_en <= 1'b0;
    else clk_10k_en <= clk_n && !clk_10k;
  end
`else
  assign clk_10k_en = 1'b0;
`endif
endmodule
